dp_mem_arbiter: RTL

DP_MEM_ARBITER -- requirements
Module: dp_mem_arbiter

---
 rtl/dp_mem_arbiter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/dp_mem_arbiter.sv
// dp_mem_arbiter: round-robin arbiter sharing one memory adapter
// between N_REQ requesters, one read or write transaction at a time.
module dp_mem_arbiter #(
  parameter int N_REQ = 2
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [N_REQ-1:0]     rq_read_req,
  input  logic [32*N_REQ-1:0]  rq_read_addr,
  output logic [31:0]          rq_read_data,
  output logic [N_REQ-1:0]     rq_read_data_valid,
  input  logic [N_REQ-1:0]     rq_write_req,
  input  logic [32*N_REQ-1:0]  rq_write_addr,
  input  logic [32*N_REQ-1:0]  rq_write_data,
  output logic [N_REQ-1:0]     rq_write_done,
  output logic                 read_req,
  output logic [31:0]          read_addr,
  input  logic [31:0]          read_data,
  input  logic                 read_data_valid,
  output logic                 write_req,
  output logic [31:0]          write_addr,
  output logic [31:0]          write_data,
  input  logic                 write_done,
  output logic                 busy,
  output logic [1:0]           grant_idx,
  output logic [31:0]          txn_count,
  output logic                 protocol_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_WR_ISSUE,
    S_WR_WAIT
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_last;
  logic [1:0]  r_grant;
  logic [31:0] r_rd_addr;
  logic [31:0] r_wr_addr;
  logic [31:0] r_wr_data;
  logic [31:0] r_txn;
  logic        r_err;

  logic        w_found;
  logic [1:0]  w_sel;
  logic        w_sel_rd;
  logic [31:0] w_sel_raddr;
  logic [31:0] w_sel_waddr;
  logic [31:0] w_sel_wdata;
  logic        w_rd_done;
  logic        w_wr_done;

  // round-robin pick starting one past the last grant; read wins
  always_comb begin
    int j;
    j           = 0;
    w_found     = 1'b0;
    w_sel       = '0;
    w_sel_rd    = 1'b0;
    w_sel_raddr = '0;
    w_sel_waddr = '0;
    w_sel_wdata = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      j = (int'(r_last) + k) % N_REQ;
      for (int i = 0; i < N_REQ; i++) begin
        if (!w_found && i == j &&
            (rq_read_req[i] || rq_write_req[i])) begin
          w_found     = 1'b1;
          w_sel       = 2'(i);
          w_sel_rd    = rq_read_req[i];
          w_sel_raddr = rq_read_addr[32*i +: 32];
          w_sel_waddr = rq_write_addr[32*i +: 32];
          w_sel_wdata = rq_write_data[32*i +: 32];
        end
      end
    end
  end

  assign w_rd_done = (r_state == S_RD_WAIT) && read_data_valid;
  assign w_wr_done = (r_state == S_WR_WAIT) && write_done;

  // next-state decode
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:
        if (w_found)
          w_next = w_sel_rd ? S_RD_ISSUE : S_WR_ISSUE;
      S_RD_ISSUE: w_next = S_RD_WAIT;
      S_RD_WAIT:  if (read_data_valid) w_next = S_IDLE;
      S_WR_ISSUE: w_next = S_WR_WAIT;
      S_WR_WAIT:  if (write_done) w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // grant, address and data capture at selection time
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_last    <= 2'(N_REQ - 1);
      r_grant   <= '0;
      r_rd_addr <= '0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else if (r_state == S_IDLE && w_found) begin
      r_last  <= w_sel;
      r_grant <= w_sel;
      if (w_sel_rd) begin
        r_rd_addr <= w_sel_raddr;
      end else begin
        r_wr_addr <= w_sel_waddr;
        r_wr_data <= w_sel_wdata;
      end
    end
  end

  // completion counter and sticky stray-pulse flag
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_txn <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_rd_done || w_wr_done)
        r_txn <= r_txn + 32'd1;
      if ((read_data_valid && r_state != S_RD_WAIT) ||
          (write_done && r_state != S_WR_WAIT))
        r_err <= 1'b1;
    end
  end

  // route completions back to the granted requester only
  always_comb begin
    rq_read_data_valid = '0;
    rq_write_done      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (r_grant == 2'(i)) begin
        rq_read_data_valid[i] = w_rd_done;
        rq_write_done[i]      = w_wr_done;
      end
    end
  end

  assign rq_read_data = read_data;
  assign read_req     = (r_state == S_RD_ISSUE);
  assign write_req    = (r_state == S_WR_ISSUE);
  assign read_addr    = r_rd_addr;
  assign write_addr   = r_wr_addr;
  assign write_data   = r_wr_data;
  assign busy         = (r_state != S_IDLE);
  assign grant_idx    = r_grant;
  assign txn_count    = r_txn;
  assign protocol_err = r_err;

endmodule
